// File: rtl/usb_pll_supervisor_if.sv
// Purpose: groups the PLL supervisor's lock input, status outputs and loss counters.
// Latency: none (wires only).
// Backpressure: none; all signals are level or single-cycle pulse.
// Ports (signals):
//   lock        - raw PLL lock flag, asynchronous to clk
//   loss_clr    - clears loss_count / loss_sticky on the next edge
//   usb_rst     - active-high synchronous reset for the USB domain
//   clk_ready   - clock qualified and stable
//   frame_tick  - one-cycle pulse every TICK_PERIOD cycles while ready
//   loss_count  - saturating count of lock-loss events
//   loss_sticky - set on any lock-loss event, held until cleared
interface usb_pll_supervisor_if;
  logic       lock;
  logic       loss_clr;
  logic       usb_rst;
  logic       clk_ready;
  logic       frame_tick;
  logic [7:0] loss_count;
  logic       loss_sticky;

  // Supervisor side
  modport slave (
    input  lock,
    input  loss_clr,
    output usb_rst,
    output clk_ready,
    output frame_tick,
    output loss_count,
    output loss_sticky
  );

  // PLL / system controller side
  modport master (
    output lock,
    output loss_clr,
    input  usb_rst,
    input  clk_ready,
    input  frame_tick,
    input  loss_count,
    input  loss_sticky
  );
endinterface

// File: rtl/usb_pll_supervisor.sv
// Purpose: qualifies the PLL lock flag, releases the USB-domain reset once lock has
//   been stable, generates the 1 ms frame tick and counts lock-loss events.
// Latency: release SYNC_STAGES+LOCK_STABLE_CYCLES cycles after lock is first sampled
//   high; drop SYNC_STAGES+1 edges after lock is first sampled low.
// Backpressure: none; outputs are registered levels/pulses.
// Ports:
//   clk - 48 MHz PLL output clock (rising edge)
//   rst - synchronous active-high reset
//   sup - usb_pll_supervisor_if.slave (lock, loss_clr in; usb_rst, clk_ready,
//         frame_tick, loss_count, loss_sticky out)
module usb_pll_supervisor #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 4800,
  parameter int TICK_PERIOD        = 48000
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_pll_supervisor_if.slave   sup
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] TICK_LAST   = 16'(TICK_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t      state_q;
  logic [15:0] stable_cnt_q;
  logic [15:0] tick_cnt_q;
  logic        usb_rst_q;
  logic        clk_ready_q;
  logic        frame_tick_q;
  logic [7:0]  loss_count_q;
  logic        loss_sticky_q;

  logic [7:0]  loss_base_d;
  logic [7:0]  loss_count_d;

  // Lock synchronizer; only the last stage is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sup.lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Count value for a loss event. A simultaneous clear is applied first, so a
  // collision lands on 1 rather than being lost.
  always_comb begin
    loss_base_d  = sup.loss_clr ? 8'd0 : loss_count_q;
    loss_count_d = (loss_base_d == 8'hFF) ? loss_base_d : loss_base_d + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      stable_cnt_q  <= '0;
      tick_cnt_q    <= '0;
      usb_rst_q     <= 1'b1;
      clk_ready_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
      loss_count_q  <= '0;
      loss_sticky_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;

      // Plain clear; a loss event below overrides it with the post-clear value.
      if (sup.loss_clr) begin
        loss_count_q  <= '0;
        loss_sticky_q <= 1'b0;
      end

      case (state_q)
        WAIT_LOCK: begin
          stable_cnt_q <= '0;
          tick_cnt_q   <= '0;
          usb_rst_q    <= 1'b1;
          clk_ready_q  <= 1'b0;
          if (lock_s) begin
            state_q <= STABILIZE;
          end
        end

        STABILIZE: begin
          if (!lock_s) begin
            // Drop before release is not a loss event: the clock was never handed out.
            state_q      <= WAIT_LOCK;
            stable_cnt_q <= '0;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_q      <= RUN;
            stable_cnt_q <= '0;
            tick_cnt_q   <= '0;
            usb_rst_q    <= 1'b0;
            clk_ready_q  <= 1'b1;
          end else begin
            stable_cnt_q <= stable_cnt_q + 16'd1;
          end
        end

        RUN: begin
          if (!lock_s) begin
            // Lock loss wins over a coincident tick: no pulse while leaving RUN.
            state_q       <= WAIT_LOCK;
            tick_cnt_q    <= '0;
            usb_rst_q     <= 1'b1;
            clk_ready_q   <= 1'b0;
            loss_count_q  <= loss_count_d;
            loss_sticky_q <= 1'b1;
          end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q   <= '0;
            frame_tick_q <= 1'b1;
          end else begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
          end
        end

        default: begin
          state_q      <= WAIT_LOCK;
          stable_cnt_q <= '0;
          tick_cnt_q   <= '0;
          usb_rst_q    <= 1'b1;
          clk_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sup.usb_rst     = usb_rst_q;
  assign sup.clk_ready   = clk_ready_q;
  assign sup.frame_tick  = frame_tick_q;
  assign sup.loss_count  = loss_count_q;
  assign sup.loss_sticky = loss_sticky_q;

endmodule
